// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  localparam int unsigned BCD_W   = 8;
  localparam logic [7:0]  BCD_MAX = 8'h99;

  // Two-digit BCD increment; 99 rolls over to 00.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_lap_counter_edge_detect.sv
// Rising-edge detector for a debounced button level.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Resets high so a button held through reset release gives no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b1;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/stopwatch_lap_counter.sv
// Stopwatch timekeeping: run/pause/clear FSM, prescaler, BCD time and lap capture.
module stopwatch_lap_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 100_000_000,
  parameter int unsigned PRESC_W        = $clog2(TICKS_PER_UNIT)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [7:0] time_bcd,
  output logic [7:0] lap_sample,
  output logic       lap_valid,
  output logic       running,
  output logic       wrap
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_UNIT - 1);

  logic ss_rise, lap_rise, clr_rise;

  edge_detect u_ed_ss  (.clk(clk), .reset(reset), .d_i(btn_start_stop), .rise_o(ss_rise));
  edge_detect u_ed_lap (.clk(clk), .reset(reset), .d_i(btn_lap),        .rise_o(lap_rise));
  edge_detect u_ed_clr (.clk(clk), .reset(reset), .d_i(btn_clear),      .rise_o(clr_rise));

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BCD_W-1:0]   time_q, time_d;
  logic [BCD_W-1:0]   lap_sample_q, lap_sample_d;
  logic               lap_valid_q, lap_valid_d;
  logic               wrap_q, wrap_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      time_q       <= '0;
      lap_sample_q <= '0;
      lap_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
      lap_sample_q <= lap_sample_d;
      lap_valid_q  <= lap_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    time_d       = time_q;
    lap_sample_d = lap_sample_q;
    lap_valid_d  = 1'b0;
    wrap_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (ss_rise) state_d = RUN;
      end
      RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          time_d  = bcd_inc(time_q);
          wrap_d  = (time_q == BCD_MAX);
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        // Capture takes the pre-increment time.
        if (lap_rise) begin
          lap_valid_d  = 1'b1;
          lap_sample_d = time_q;
        end
        if (ss_rise) state_d = PAUSE;
      end
      PAUSE: begin
        // Clear overrides both start/stop and lap in the same cycle.
        if (clr_rise) begin
          state_d = IDLE;
          time_d  = '0;
          presc_d = '0;
        end else begin
          if (lap_rise) begin
            lap_valid_d  = 1'b1;
            lap_sample_d = time_q;
          end
          if (ss_rise) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign time_bcd   = time_q;
  assign lap_sample = lap_sample_q;
  assign lap_valid  = lap_valid_q;
  assign wrap       = wrap_q;
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_stopwatch_lap_counter.sv
// Directed plus randomized checks of stopwatch_lap_counter against an elapsed-units model.
module tb_stopwatch_lap_counter;

  localparam int T = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start_stop = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic [7:0] time_bcd, lap_sample;
  logic       lap_valid, running, wrap;

  stopwatch_lap_counter #(.TICKS_PER_UNIT(T)) dut (
    .clk(clk), .reset(reset),
    .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .time_bcd(time_bcd), .lap_sample(lap_sample), .lap_valid(lap_valid),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;

  // Model: elapsed units 0..99 as an integer, sub-unit cycle count, mode.
  int m_mode, m_units, m_sub, m_sample;
  bit m_lv, m_wrap, p_ss, p_lap, p_clr;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("time_bcd", 32'(time_bcd), 32'(to_bcd(m_units)));
    check("running", 32'(running), 32'(m_mode == M_RUN));
    check("lap_valid", 32'(lap_valid), 32'(m_lv));
    check("lap_sample", 32'(lap_sample), 32'(to_bcd(m_sample)));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_units = 0; m_sub = 0; m_sample = 0;
    m_lv = 0; m_wrap = 0; p_ss = 1; p_lap = 1; p_clr = 1;
  endtask

  // Drive one cycle of button levels, advance the model, check after the edge.
  task automatic cyc(input bit ss, input bit lap, input bit clr);
    bit r_ss, r_lap, r_clr;
    btn_start_stop = ss; btn_lap = lap; btn_clear = clr;
    r_ss = ss & ~p_ss; r_lap = lap & ~p_lap; r_clr = clr & ~p_clr;
    p_ss = ss; p_lap = lap; p_clr = clr;
    m_lv = 0; m_wrap = 0;
    if (m_mode == M_IDLE) begin
      m_sub = 0;
      if (r_ss) m_mode = M_RUN;
    end else if (m_mode == M_PAUSE && r_clr) begin
      m_mode = M_IDLE; m_units = 0; m_sub = 0;
    end else begin
      if (r_lap) begin m_lv = 1; m_sample = m_units; end
      if (m_mode == M_RUN) begin
        m_sub++;
        if (m_sub == T) begin
          m_sub = 0;
          m_wrap = (m_units == 99);
          m_units = (m_units + 1) % 100;
        end
      end
      if (r_ss) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_units != target && n < 2000) begin cyc(0, 0, 0); n++; end
    check("run_to", 32'(time_bcd), 32'(to_bcd(target)));
  endtask

  initial begin
    int strobes;
    model_reset();
    reset = 1'b1; #12; reset = 1'b0;
    @(negedge clk);
    check_all();

    repeat (20) cyc(0, 0, 0);
    check("idle_time", 32'(time_bcd), 32'h00);

    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    check("time_after_40", 32'(time_bcd), 32'h10);

    repeat (356) cyc(0, 0, 0);
    check("time_99", 32'(time_bcd), 32'h99);
    repeat (4) cyc(0, 0, 0);
    check("wrap_time", 32'(time_bcd), 32'h00);
    check("wrap_pulse", 32'(wrap), 32'h1);
    cyc(0, 0, 0);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    run_to(5);
    cyc(0, 1, 0);
    check("lap_strobe", 32'(lap_valid), 32'h1);
    check("lap_05", 32'(lap_sample), 32'h05);
    cyc(0, 0, 0);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0);
      if (lap_valid) strobes++;
    end
    cyc(0, 0, 0);
    check("held_lap_strobes", 32'(strobes), 32'd1);

    run_to(12);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("paused", 32'(running), 32'h0);
    cyc(1, 0, 1);
    check("clear_wins_time", 32'(time_bcd), 32'h00);
    check("clear_wins_run", 32'(running), 32'h0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (6) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("clear_in_run_ignored", 32'(running), 32'h1);
    repeat (8) cyc(0, 0, 0);

    run_to(37);
    btn_start_stop = 1'b1;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    check("reset_time", 32'(time_bcd), 32'h00);
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) cyc(1, 0, 0);
    check("held_through_reset", 32'(running), 32'h0);
    cyc(0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit ss, lp, cl;
      ss = ($urandom_range(0, 9) == 0) ? ~btn_start_stop : btn_start_stop;
      lp = ($urandom_range(0, 3) == 0) ? ~btn_lap : btn_lap;
      cl = ($urandom_range(0, 14) == 0) ? ~btn_clear : btn_clear;
      cyc(ss, lp, cl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
